// File: rtl/if_id_stage.sv
// Fetch stage and IF/ID register: PC, next-PC select, bubble insertion.
// Branch redirect beats jump beats stall; reset beats everything.
module if_id_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        jump_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic [5:0]  instr_op_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o,
  output logic        flush_o
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_plus4;
  logic [31:0] jump_target;
  logic        jump_go;

  assign pc_plus4    = pc_q + 32'd4;
  // Jump target comes from the instruction already sitting in IF/ID.
  assign jump_target = {pcp4_q[31:28], instr_q[25:0], 2'b00};
  assign jump_go     = jump_i & valid_q;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    if (branch_taken_i) begin
      pc_d    = branch_target_i;
      instr_d = NOP_WORD;
      pcp4_d  = 32'd0;
      valid_d = 1'b0;
    end else if (jump_go) begin
      pc_d    = jump_target;
      instr_d = NOP_WORD;
      pcp4_d  = 32'd0;
      valid_d = 1'b0;
    end else if (!stall_i) begin
      pc_d    = pc_plus4;
      instr_d = imem_data_i;
      pcp4_d  = pc_plus4;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_WORD;
      pcp4_q  <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
    end
  end

  assign imem_addr_o = pc_q;
  assign pc_o        = pc_q;
  assign instr_o     = instr_q;
  assign instr_op_o  = instr_q[31:26];
  assign pc_plus4_o  = pcp4_q;
  assign valid_o     = valid_q;
  assign flush_o     = ~rst_i & (branch_taken_i | jump_go);

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage with a small combinational imem.
// Each scenario task drives inputs and checks outputs inline.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        jump;
  logic        br;
  logic [31:0] br_tgt;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [31:0] pcp4;
  logic        valid;
  logic        flush;
  logic [31:0] w0;

  int compared = 0;
  int mismatched = 0;

  if_id_stage dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .jump_i(jump),
    .branch_taken_i(br), .branch_target_i(br_tgt),
    .imem_addr_o(imem_addr), .imem_data_i(imem_data),
    .pc_o(pc), .instr_o(instr), .instr_op_o(op),
    .pc_plus4_o(pcp4), .valid_o(valid), .flush_o(flush)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (imem_addr)
      32'h0000_0000: imem_data = w0;
      32'h0000_0004: imem_data = 32'h2009_0003;
      32'h0000_0040: imem_data = 32'h2010_0001;
      default:       imem_data = {16'hDEAD, imem_addr[15:0]};
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; jump = 0; br = 0; br_tgt = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1; idle();
    step();
    rst = 0;
    #1;
  endtask

  task automatic test_reset();
    w0 = 32'h2008_0005;
    do_reset();
    compared++; if (pc !== 32'h0) begin mismatched++;
      $display("FAIL reset_pc got %h exp %h", pc, 32'h0); end
    compared++; if (instr !== 32'h0) begin mismatched++;
      $display("FAIL reset_instr got %h exp %h", instr, 32'h0); end
    compared++; if (pcp4 !== 32'h0) begin mismatched++;
      $display("FAIL reset_pcp4 got %h exp %h", pcp4, 32'h0); end
    compared++; if (valid !== 1'b0) begin mismatched++;
      $display("FAIL reset_valid got %b exp 0", valid); end
    compared++; if (flush !== 1'b0) begin mismatched++;
      $display("FAIL reset_flush got %b exp 0", flush); end
  endtask

  task automatic test_free_run();
    step();
    compared++; if (pc !== 32'h4) begin mismatched++;
      $display("FAIL run1_pc got %h exp %h", pc, 32'h4); end
    compared++; if (instr !== 32'h2008_0005) begin mismatched++;
      $display("FAIL run1_instr got %h exp %h", instr, 32'h2008_0005); end
    compared++; if (op !== 6'b001000) begin mismatched++;
      $display("FAIL run1_op got %b exp 001000", op); end
    compared++; if (pcp4 !== 32'h4) begin mismatched++;
      $display("FAIL run1_pcp4 got %h exp %h", pcp4, 32'h4); end
    compared++; if (valid !== 1'b1) begin mismatched++;
      $display("FAIL run1_valid got %b exp 1", valid); end
    step();
    compared++; if (pc !== 32'h8) begin mismatched++;
      $display("FAIL run2_pc got %h exp %h", pc, 32'h8); end
    compared++; if (instr !== 32'h2009_0003) begin mismatched++;
      $display("FAIL run2_instr got %h exp %h", instr, 32'h2009_0003); end
    compared++; if (op !== 6'b001000) begin mismatched++;
      $display("FAIL run2_op got %b exp 001000", op); end
  endtask

  task automatic test_stall();
    stall = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      compared++; if (pc !== 32'h8 || imem_addr !== 32'h8) begin
        mismatched++;
        $display("FAIL stall_pc[%0d] got %h/%h exp 8", i, pc, imem_addr);
      end
      compared++; if (instr !== 32'h2009_0003) begin mismatched++;
        $display("FAIL stall_instr[%0d] got %h exp 20090003", i, instr); end
      compared++; if (pcp4 !== 32'h8 || valid !== 1'b1) begin
        mismatched++;
        $display("FAIL stall_hold[%0d] got %h/%b exp 8/1", i, pcp4, valid);
      end
    end
    stall = 0;
    step();
    compared++; if (pc !== 32'hC) begin mismatched++;
      $display("FAIL unstall_pc got %h exp %h", pc, 32'hC); end
    compared++; if (instr !== 32'hDEAD_0008 || pcp4 !== 32'hC) begin
      mismatched++;
      $display("FAIL unstall_ifid got %h/%h exp dead0008/c", instr, pcp4);
    end
  endtask

  task automatic test_jump();
    w0 = 32'h0800_0010;
    do_reset();
    jump = 1;
    #1;
    compared++; if (flush !== 1'b0) begin mismatched++;
      $display("FAIL jump_novalid_flush got %b exp 0", flush); end
    step();
    compared++; if (pc !== 32'h4 || instr !== 32'h0800_0010) begin
      mismatched++;
      $display("FAIL jump_novalid got %h/%h exp 4/08000010", pc, instr);
    end
    compared++; if (flush !== 1'b1) begin mismatched++;
      $display("FAIL jump_flush got %b exp 1", flush); end
    step();
    jump = 0;
    compared++; if (pc !== 32'h40) begin mismatched++;
      $display("FAIL jump_pc got %h exp %h", pc, 32'h40); end
    compared++; if (instr !== 32'h0 || valid !== 1'b0 || pcp4 !== 32'h0) begin
      mismatched++;
      $display("FAIL jump_bubble got %h/%b/%h exp 0/0/0", instr, valid, pcp4);
    end
    step();
    compared++; if (pc !== 32'h44 || instr !== 32'h2010_0001) begin
      mismatched++;
      $display("FAIL jump_fetch got %h/%h exp 44/20100001", pc, instr);
    end
    compared++; if (pcp4 !== 32'h44 || valid !== 1'b1) begin mismatched++;
      $display("FAIL jump_fetch_p4 got %h/%b exp 44/1", pcp4, valid); end
  endtask

  task automatic test_branch_priority();
    br = 1; br_tgt = 32'h100; jump = 1; stall = 1;
    #1;
    compared++; if (flush !== 1'b1) begin mismatched++;
      $display("FAIL br_flush got %b exp 1", flush); end
    step();
    idle();
    compared++; if (pc !== 32'h100) begin mismatched++;
      $display("FAIL br_pc got %h exp %h", pc, 32'h100); end
    compared++; if (valid !== 1'b0 || instr !== 32'h0) begin mismatched++;
      $display("FAIL br_bubble got %b/%h exp 0/0", valid, instr); end
  endtask

  task automatic test_wrap();
    br = 1; br_tgt = 32'hFFFF_FFFC;
    step();
    idle();
    compared++; if (pc !== 32'hFFFF_FFFC) begin mismatched++;
      $display("FAIL wrap_pre got %h exp fffffffc", pc); end
    step();
    compared++; if (pc !== 32'h0 || pcp4 !== 32'h0) begin mismatched++;
      $display("FAIL wrap_pc got %h/%h exp 0/0", pc, pcp4); end
    compared++; if (valid !== 1'b1 || instr !== 32'hDEAD_FFFC) begin
      mismatched++;
      $display("FAIL wrap_ifid got %b/%h exp 1/deadfffc", valid, instr);
    end
  endtask

  task automatic test_reset_dominates();
    w0 = 32'h2008_0005;
    step();
    rst = 1; stall = 1; br = 1; br_tgt = 32'h200;
    #1;
    compared++; if (flush !== 1'b0) begin mismatched++;
      $display("FAIL rstdom_flush got %b exp 0", flush); end
    step();
    rst = 0; idle();
    compared++; if (pc !== 32'h0 || instr !== 32'h0) begin mismatched++;
      $display("FAIL rstdom_state got %h/%h exp 0/0", pc, instr); end
    compared++; if (valid !== 1'b0 || pcp4 !== 32'h0) begin mismatched++;
      $display("FAIL rstdom_valid got %b/%h exp 0/0", valid, pcp4); end
  endtask

  initial begin
    rst = 1; w0 = 32'h0; idle();
    test_reset();
    test_free_run();
    test_stall();
    test_jump();
    test_branch_priority();
    test_wrap();
    test_reset_dominates();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the pipelined MIPS core.
- Holds the PC, addresses the combinational instruction memory, and selects the next PC from sequential, jump or taken-branch targets.
- Latches the fetched word into IF/ID and presents the opcode field to the downstream decoder.
- Supports hazard stall, control-hazard flush and a valid bit so bubbles are distinguishable from real instructions.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_WORD, 32'h0000_0000, word placed in IF/ID on flush or reset (sll $0,$0,0).

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- stall_i  input  1  from hazard unit; hold PC and IF/ID.
- jump_i  input  1  decoder jump in ID; applies to the instruction currently in IF/ID.
- branch_taken_i  input  1  taken branch resolved in EX.
- branch_target_i  input  32  target of the taken branch.
- imem_addr_o  output  32  instruction memory address; equals pc_o.
- imem_data_i  input  32  instruction word, combinational on imem_addr_o.
- pc_o  output  32  current fetch PC.
- instr_o  output  32  IF/ID instruction.
- instr_op_o  output  6  instr_o[31:26], feeds the decoder opcode input.
- pc_plus4_o  output  32  IF/ID copy of the fetch PC+4.
- valid_o  output  1  IF/ID holds a real instruction.
- flush_o  output  1  combinational; high when this cycle's fetch is discarded.

Behaviour:
- Reset (rst_i=1 at an edge): pc_o=RESET_PC, instr_o=NOP_WORD, pc_plus4_o=0, valid_o=0. Reset dominates every other input, including mid-stall and mid-redirect.
- Derived signals:
  - pc_plus4 = pc_o+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
  - jump_target = {pc_plus4_o[31:28], instr_o[25:0], 2'b00}, built from the IF/ID contents, not the current fetch.
- Next-state priority, highest first:
  1. branch_taken_i=1: pc<=branch_target_i; IF/ID<=NOP_WORD, pc_plus4_o<=0, valid_o<=0. Wins over jump_i and stall_i because the branch is the older instruction.
  2. jump_i=1 and valid_o=1: pc<=jump_target; IF/ID<=bubble as above. jump_i with valid_o=0 is ignored.
  3. stall_i=1: pc, instr_o, pc_plus4_o and valid_o all hold.
  4. Otherwise: pc<=pc_plus4; instr_o<=imem_data_i; pc_plus4_o<=pc_plus4; valid_o<=1.
- flush_o = branch_taken_i | (jump_i & valid_o), with rst_i forcing it to 0.
- Latency:
  - A fetched word reaches instr_o one cycle after its address is on pc_o.
  - Jump penalty is 1 bubble; taken-branch penalty is 1 bubble at this stage (EX-side flush is handled elsewhere).
- instr_op_o is purely combinational from instr_o; no extra register.
- Stall held for N cycles: outputs stay constant for all N cycles, and imem_addr_o stays constant.
- The stage tracks no state machine beyond the PC and the IF/ID register. A redirect occurring during a multi-cycle stall ends the stall's effect on PC.
- No X propagation: all registers take defined values from reset.

Test Plan:
- Reset, then 3 free-running cycles with imem returning 32'h2008_0005 at addr 0 and 32'h2009_0003 at addr 4:
  - pc_o goes 0 -> 4 -> 8.
  - instr_o=32'h2008_0005 with instr_op_o=6'b001000, pc_plus4_o=4, valid_o=1.
  - Next cycle instr_o=32'h2009_0003.
- stall_i=1 for 2 cycles with pc_o=8: pc_o stays 8, instr_o/pc_plus4_o/valid_o unchanged. Release -> pc_o=12.
- IF/ID holds 32'h0800_0010 (j), pc_plus4_o=4, jump_i=1:
  - Same cycle flush_o=1.
  - Next edge pc_o=32'h0000_0040, instr_o=0, valid_o=0.
  - The following cycle fetches from 0x40.
- branch_taken_i=1, branch_target_i=32'h0000_0100, with jump_i=1 and stall_i=1 simultaneously: pc_o=32'h100, valid_o=0, flush_o=1 (branch priority).
- pc_o=32'hFFFF_FFFC, no stall: next pc_o=0, pc_plus4_o=0, valid_o=1.
- rst_i asserted while stall_i=1 and branch_taken_i=1 (target 32'h200): pc_o=RESET_PC, instr_o=0, valid_o=0, flush_o=0.
